// File: rtl/bist_seq_ctrl_if.sv
// bist_seq_ctrl_if: CUT-side bus of the BIST sequencer.
// master = sequencer (drives load/state/step/x), slave = circuit under test (drives y).
interface bist_seq_ctrl_if #(
    parameter int STATE_W = 4
) ();
    logic               CUT_LOAD;
    logic [STATE_W-1:0] CUT_STATE;
    logic               CUT_STEP;
    logic               CUT_X;
    logic               CUT_Y;

    modport master (
        output CUT_LOAD,
        output CUT_STATE,
        output CUT_STEP,
        output CUT_X,
        input  CUT_Y
    );

    modport slave (
        input  CUT_LOAD,
        input  CUT_STATE,
        input  CUT_STEP,
        input  CUT_X,
        output CUT_Y
    );
endinterface

// File: rtl/bist_seq_ctrl.sv
// bist_seq_ctrl: runs the user BIST vector {state, x, y} from USER_TEST against the CUT.
// Loads the initial state, steps the CUT once per clock with x, compares the CUT output
// against y, and reports pass / mismatch count / first failing step.
// Optional feature macro: BIST_EARLY_STOP_EN (stop at the first mismatch).
module bist_seq_ctrl #(
    parameter int STATE_W = 4,
    parameter int VEC_LEN = 1024,
    parameter int IDX_W   = $clog2(VEC_LEN),
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic [STATE_W+2*VEC_LEN-1:0] USER_TEST,
    output logic                         SHIFT_BLOCK,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         PASS,
    output logic [CNT_W-1:0]             ERR_COUNT,
    output logic [IDX_W-1:0]             FIRST_FAIL,
    bist_seq_ctrl_if.master              cut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_err;
    logic [IDX_W-1:0]     r_first;
    logic                 r_pass;

    logic [VEC_LEN-1:0]   w_x_vec;
    logic [VEC_LEN-1:0]   w_y_vec;
    logic                 w_mismatch;

    assign w_y_vec    = USER_TEST[VEC_LEN-1:0];
    assign w_x_vec    = USER_TEST[2*VEC_LEN-1:VEC_LEN];
    assign w_mismatch = (r_state == S_RUN) && (cut.CUT_Y != w_y_vec[r_idx]);

    // Next-state selection; ABORT/reset are handled in the state register.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (START) w_next = S_LOAD;
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
`ifdef BIST_EARLY_STOP_EN
                if ((r_idx == LAST_IDX) || w_mismatch) w_next = S_DONE;
`else
                if (r_idx == LAST_IDX) w_next = S_DONE;
`endif
            end
            S_DONE: if (START) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // State, step index and result registers; ABORT acts like reset but below RST_N.
    always_ff @(posedge CLK) begin
        if (!RST_N || ABORT) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_err   <= '0;
            r_first <= '1;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    r_idx   <= '0;
                    r_err   <= '0;
                    r_first <= '1;
                    r_pass  <= 1'b0;
                end
                S_RUN: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_mismatch) begin
                        r_err <= r_err + CNT_W'(1);
                        if (r_err == '0) r_first <= r_idx;
                    end
                    // PASS must already include the compare of the step being left.
                    if (w_next == S_DONE) r_pass <= (r_err == '0) && !w_mismatch;
                end
                default: ;
            endcase
        end
    end

    assign BUSY          = (r_state == S_LOAD) || (r_state == S_RUN);
    assign SHIFT_BLOCK   = BUSY;
    assign DONE          = (r_state == S_DONE);
    assign PASS          = DONE && r_pass;
    assign ERR_COUNT     = r_err;
    assign FIRST_FAIL    = r_first;

    assign cut.CUT_LOAD  = (r_state == S_LOAD);
    assign cut.CUT_STEP  = (r_state == S_RUN);
    assign cut.CUT_X     = (r_state == S_RUN) && w_x_vec[r_idx];
    assign cut.CUT_STATE = USER_TEST[STATE_W+2*VEC_LEN-1 -: STATE_W];

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// tb_bist_seq_ctrl: directed + randomized checks of bist_seq_ctrl with an echo CUT.
// Two instances: VEC_LEN=8 for the directed/random cases and the default VEC_LEN=1024.
module tb_bist_seq_ctrl;
    localparam int SW  = 4;
    localparam int VS  = 8;
    localparam int VL  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start8, abort8, start1k, abort1k;
    logic [SW+2*VS-1:0] ut8;
    logic [SW+2*VL-1:0] ut1k;

    logic sb8, busy8, done8, pass8;
    logic [3:0] err8;
    logic [2:0] ff8;
    logic sb1k, busy1k, done1k, pass1k;
    logic [10:0] err1k;
    logic [9:0] ff1k;

    bist_seq_ctrl_if #(.STATE_W(SW)) cif8 ();
    bist_seq_ctrl_if #(.STATE_W(SW)) cif1k ();

    // CUT model: output echoes the x input in the same cycle
    assign cif8.CUT_Y  = cif8.CUT_X;
    assign cif1k.CUT_Y = cif1k.CUT_X;

    bist_seq_ctrl #(.STATE_W(SW), .VEC_LEN(VS)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .ABORT(abort8), .USER_TEST(ut8),
        .SHIFT_BLOCK(sb8), .BUSY(busy8), .DONE(done8), .PASS(pass8),
        .ERR_COUNT(err8), .FIRST_FAIL(ff8), .cut(cif8.master)
    );

    bist_seq_ctrl #(.STATE_W(SW), .VEC_LEN(VL)) u_dut1k (
        .CLK(clk), .RST_N(rst_n), .START(start1k), .ABORT(abort1k), .USER_TEST(ut1k),
        .SHIFT_BLOCK(sb1k), .BUSY(busy1k), .DONE(done1k), .PASS(pass1k),
        .ERR_COUNT(err1k), .FIRST_FAIL(ff1k), .cut(cif1k.master)
    );

    // Observation mux so one run task serves both instances
    logic sel1k;
    logic s_done, s_busy, s_sb, s_step, s_load, s_x, s_pass;
    logic [31:0] s_err, s_ff, s_cstate;
    always_comb begin
        s_done   = sel1k ? done1k : done8;
        s_busy   = sel1k ? busy1k : busy8;
        s_sb     = sel1k ? sb1k : sb8;
        s_step   = sel1k ? cif1k.CUT_STEP : cif8.CUT_STEP;
        s_load   = sel1k ? cif1k.CUT_LOAD : cif8.CUT_LOAD;
        s_x      = sel1k ? cif1k.CUT_X : cif8.CUT_X;
        s_pass   = sel1k ? pass1k : pass8;
        s_err    = sel1k ? 32'(err1k) : 32'(err8);
        s_ff     = sel1k ? 32'(ff1k) : 32'(ff8);
        s_cstate = sel1k ? 32'(cif1k.CUT_STATE) : 32'(cif8.CUT_STATE);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel1k) start1k = v;
        else start8 = v;
    endtask

    // One complete run; expectations come from a direct count over x^y
    task automatic run(input int v, input logic [3:0] st, input logic [VL-1:0] xv,
                       input logic [VL-1:0] yv, input bit busy_start);
        int exp_err, exp_first, exp_lat, exp_steps, n, steps, sbc;
        bit xok;
        logic [31:0] allones;
        exp_err = 0;
        exp_first = -1;
        for (int i = 0; i < v; i++) begin
            if (xv[i] != yv[i]) begin
                if (exp_first < 0) exp_first = i;
                exp_err++;
            end
        end
        allones = (v == VS) ? 32'd7 : 32'd1023;
        exp_lat = v + 2;
        exp_steps = v;
`ifdef BIST_EARLY_STOP_EN
        if (exp_err > 0) begin
            exp_err = 1;
            exp_lat = exp_first + 3;
            exp_steps = exp_first + 1;
        end
`endif
        sel1k = (v != VS);
        if (v == VS) ut8 = {st, xv[VS-1:0], yv[VS-1:0]};
        else ut1k = {st, xv, yv};
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("load_pulse", 32'(s_load), 32'd1);
        check("cut_state", s_cstate, 32'(st));
        n = 1;
        steps = 0;
        sbc = s_sb ? 1 : 0;
        xok = 1'b1;
        while (!s_done && n < v + 20) begin
            if (busy_start) set_start(1'($urandom_range(0, 1)));
            tick();
            set_start(1'b0);
            n++;
            if (s_step) begin
                if (s_x !== xv[steps]) xok = 1'b0;
                steps++;
            end
            if (s_sb) sbc++;
        end
        check("done_latency", 32'(n), 32'(exp_lat));
        check("step_count", 32'(steps), 32'(exp_steps));
        check("shift_block_cycles", 32'(sbc), 32'(exp_lat - 1));
        check("cut_x_sequence", 32'(xok), 32'd1);
        check("pass", 32'(s_pass), 32'(exp_err == 0));
        check("err_count", s_err, 32'(exp_err));
        check("first_fail", s_ff, (exp_first < 0) ? allones : 32'(exp_first));
        check("busy_in_done", 32'(s_busy), 32'd0);
        tick();
        check("done_hold", 32'(s_done), 32'd1);
        check("err_hold", s_err, 32'(exp_err));
    endtask

    task automatic check_reset8(input string tag);
        check({tag, "_busy"}, 32'(busy8), 32'd0);
        check({tag, "_done"}, 32'(done8), 32'd0);
        check({tag, "_pass"}, 32'(pass8), 32'd0);
        check({tag, "_sb"}, 32'(sb8), 32'd0);
        check({tag, "_load"}, 32'(cif8.CUT_LOAD), 32'd0);
        check({tag, "_step"}, 32'(cif8.CUT_STEP), 32'd0);
        check({tag, "_x"}, 32'(cif8.CUT_X), 32'd0);
        check({tag, "_err"}, 32'(err8), 32'd0);
        check({tag, "_ff"}, 32'(ff8), 32'd7);
    endtask

    initial begin
        logic [VL-1:0] xv, yv, mask;
        rst_n = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; start1k = 1'b0; abort1k = 1'b0;
        ut8 = '0; ut1k = '0; sel1k = 1'b0;
        tick(); tick();
        check_reset8("reset");
        check("reset_busy1k", 32'(busy1k), 32'd0);
        check("reset_ff1k", 32'(ff1k), 32'd1023);
        rst_n = 1'b1;
        tick();

        // Directed patterns from the test plan
        run(VS, 4'hA, VL'(8'h5C), VL'(8'h5C), 1'b0);
        run(VS, 4'hA, VL'(8'h5C), VL'(8'h54), 1'b0);
        run(VS, 4'hA, VL'(8'h5C), VL'(8'hA3), 1'b0);

        // ABORT at RUN step 4 (mismatch placed at step 7 so both builds are still running)
        sel1k = 1'b0;
        ut8 = {4'h3, 8'h5C, 8'hDC};
        start8 = 1'b1; tick(); start8 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_pre_step", 32'(cif8.CUT_STEP), 32'd1);
        abort8 = 1'b1; tick(); abort8 = 1'b0;
        check_reset8("abort_run");

        // ABORT in DONE clears held results
        run(VS, 4'h5, VL'(8'h5C), VL'(8'hA3), 1'b0);
        abort8 = 1'b1; tick(); abort8 = 1'b0;
        check_reset8("abort_done");

        // START together with ABORT in IDLE stays in IDLE
        start8 = 1'b1; abort8 = 1'b1; tick();
        check("start_abort_busy", 32'(busy8), 32'd0);
        check("start_abort_load", 32'(cif8.CUT_LOAD), 32'd0);
        start8 = 1'b0; abort8 = 1'b0; tick();
        check("start_abort_busy2", 32'(busy8), 32'd0);

        // Reset during RUN step 2
        ut8 = {4'h9, 8'h5C, 8'h5D};
        start8 = 1'b1; tick(); start8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0; tick();
        check_reset8("reset_run");
        rst_n = 1'b1; tick();

        // START pulses while busy are ignored
        run(VS, 4'hA, VL'(8'h5C), VL'(8'h5C), 1'b1);
        run(VS, 4'h6, VL'(8'h5C), VL'(8'h54), 1'b1);

        // Randomized short vectors, mismatch density varies per run
        for (int r = 0; r < 20; r++) begin
            xv = VL'($urandom_range(0, 255));
            mask = (r % 3 == 0) ? '0 : VL'($urandom_range(0, 255) & $urandom_range(0, 255));
            yv = xv ^ mask;
            run(VS, 4'($urandom), xv, yv, bit'(r % 2));
        end

        // Full-length vector: all-match, then sparse mismatches
        for (int i = 0; i < VL / 32; i++) xv[i*32 +: 32] = $urandom;
        run(VL, 4'hC, xv, xv, 1'b0);
        mask = '0;
        for (int i = 0; i < 5; i++) mask[$urandom_range(100, VL - 1)] = 1'b1;
        run(VL, 4'h1, xv, xv ^ mask, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bist_seq_ctrl.md
# bist_seq_ctrl

Sequencer that executes the user-defined BIST vector held in the 2052-bit user test register. On a start request it loads the initial state into the circuit under test (CUT), steps the CUT once per clock with each bit of input vector x, and compares each CUT output bit with expected vector y. It reports busy, done, pass, mismatch count and first failing step, and blocks further JTAG shifting of the test register while a run is in progress.

## Interface
- STATE_W, 4: width of the initial-state field.
- VEC_LEN, 1024: number of test steps; the x and y fields are each this wide.
- IDX_W, $clog2(VEC_LEN): width of the step index.
- CNT_W, $clog2(VEC_LEN+1): width of the mismatch counter.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  run request, sampled in IDLE or DONE.
- ABORT  in  1  cancels a run or clears results; overrides START.
- USER_TEST  in  STATE_W+2*VEC_LEN  {initial state, x, y}; y=[VEC_LEN-1:0], x=[2*VEC_LEN-1:VEC_LEN], state=top STATE_W bits.
- SHIFT_BLOCK  out  1  equals BUSY; gates the test-register shift ENABLE.
- CUT_LOAD  out  1  one-cycle pulse that loads CUT_STATE into the CUT.
- CUT_STATE  out  STATE_W  USER_TEST initial-state field, driven continuously.
- CUT_STEP  out  1  CUT clock enable, high during RUN.
- CUT_X  out  1  x bit for the current step.
- CUT_Y  in  1  CUT output (Mealy: valid in the same cycle as CUT_X).
- BUSY  out  1  high in LOAD and RUN.
- DONE  out  1  high in DONE.
- PASS  out  1  valid while DONE; 1 means zero mismatches.
- ERR_COUNT  out  CNT_W  number of mismatches.
- FIRST_FAIL  out  IDX_W  index of the first mismatching step; all-ones when there is none.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: when START=1 and ABORT=0, go to LOAD.
- LOAD, one cycle:
  - CUT_LOAD=1.
  - Clear idx to 0, ERR_COUNT to 0, FIRST_FAIL to all-ones.
  - Go to RUN.
- RUN:
  - CUT_STEP=1 and CUT_X=USER_TEST[VEC_LEN+idx].
  - Mismatch when CUT_Y != USER_TEST[idx].
  - On a mismatch, ERR_COUNT increments. If this is the first mismatch (ERR_COUNT was 0), FIRST_FAIL is set to idx.
  - idx increments each cycle.
  - After step VEC_LEN-1, go to DONE.
- DONE:
  - PASS is registered on entry and includes the final step's compare.
  - Results hold until the next START (restarts via LOAD) or ABORT.
- ABORT=1 in any state: go to IDLE next cycle, clear all results, drop CUT_STEP/CUT_LOAD immediately (combinational outputs from state).
- START while BUSY is ignored.
- USER_TEST is not latched. It must be stable while BUSY, which SHIFT_BLOCK guarantees.
- ERR_COUNT cannot overflow because CNT_W covers VEC_LEN.
- RST_N=0 has the same effect as ABORT, but takes priority over everything.

## Timing
- Reset values: BUSY=0, DONE=0, PASS=0, SHIFT_BLOCK=0, CUT_LOAD=0, CUT_STEP=0, CUT_X=0, ERR_COUNT=0, FIRST_FAIL=all-ones; state IDLE.
- START sampled in cycle t:
  - LOAD in t+1.
  - RUN in t+2 through t+VEC_LEN+1.
  - DONE=1 from t+VEC_LEN+2.
- CUT_X and CUT_STEP are combinational from the state and idx registers. CUT_Y is compared in the same cycle.
- Reset mid-run: in the cycle after RST_N is sampled low, all outputs are at reset values.

## Configuration
- BIST_EARLY_STOP_EN defined: the first mismatch in RUN moves the FSM to DONE in the next cycle with ERR_COUNT=1, FIRST_FAIL=idx and PASS=0. No further CUT_STEP is issued. Latency is mismatch step+3 cycles from START.
- Undefined: all VEC_LEN steps always run and every mismatch is counted.

## Test plan
- VEC_LEN=8, state=4'hA, x=8'h5C, CUT model echoes x, y=8'h5C -> CUT_LOAD pulse with CUT_STATE=4'hA, 8 CUT_STEP cycles, DONE at t+10, PASS=1, ERR_COUNT=0, FIRST_FAIL=3'h7.
- Same setup, y=8'h54 (bit 3 flipped) -> PASS=0, ERR_COUNT=1, FIRST_FAIL=3.
- y=8'hA3 (all bits wrong) -> ERR_COUNT=8, FIRST_FAIL=0. With BIST_EARLY_STOP_EN: DONE at t+3, ERR_COUNT=1, only 1 CUT_STEP.
- ABORT at RUN step 4 -> IDLE next cycle, BUSY=0, CUT_STEP=0, ERR_COUNT=0, DONE=0. START together with ABORT in IDLE -> remains IDLE.
- RST_N low during RUN step 2 -> all outputs at reset values next cycle. START pulses during BUSY -> ignored, DONE still at t+10.
- Default VEC_LEN=1024, all-match pattern -> SHIFT_BLOCK high for 1025 cycles, DONE at t+1026, PASS=1.
